// File: rtl/clk_en_sel.sv
// Single-clock rate selector: emits a one-cycle clock-enable strobe at one of
// P_NO_CLOCKS programmable divide ratios. Optional duty-50 level: CLK_EN_SEL_DUTY50_EN.
module clk_en_sel #(
  parameter int P_NO_CLOCKS = 4,
  parameter int P_DIV_W     = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [P_NO_CLOCKS*P_DIV_W-1:0] div_vec,
  input  logic                           sel_req,
  input  logic [P_NO_CLOCKS-1:0]         sel_vec,
  output logic                           sel_ack,
  output logic                           sel_err,
  output logic                           busy,
  output logic [P_NO_CLOCKS-1:0]         cur_sel,
  output logic                           clk_en_o
`ifdef CLK_EN_SEL_DUTY50_EN
  ,
  output logic                           clk_lvl_o
`endif
);

  typedef enum logic [1:0] {PARK, RUN, PEND} state_t;

  localparam logic [P_DIV_W-1:0]     ONE_W = P_DIV_W'(1);
  localparam logic [P_NO_CLOCKS-1:0] ONE_S = P_NO_CLOCKS'(1);

  function automatic logic is_onehot(input logic [P_NO_CLOCKS-1:0] v);
    return (v != '0) && ((v & (v - ONE_S)) == '0);
  endfunction

  // Ratio of a one-hot selection; a programmed 0 behaves as 1.
  function automatic logic [P_DIV_W-1:0] ratio_of(
    input logic [P_NO_CLOCKS-1:0]         sel,
    input logic [P_NO_CLOCKS*P_DIV_W-1:0] dv
  );
    logic [P_DIV_W-1:0] r;
    r = '0;
    for (int i = 0; i < P_NO_CLOCKS; i++)
      if (sel[i]) r = r | dv[i*P_DIV_W +: P_DIV_W];
    if (r == '0) r = ONE_W;
    return r;
  endfunction

  state_t                 state, state_nxt;
  logic [P_DIV_W-1:0]     cnt, cnt_nxt;
  logic [P_DIV_W-1:0]     n_cur, n_nxt;
  logic [P_NO_CLOCKS-1:0] cur_nxt;
  logic [P_NO_CLOCKS-1:0] pend, pend_nxt, pend_val;
  logic                   err_owed, owed_nxt;
  logic                   ack_nxt, err_nxt, en_nxt, busy_nxt;
  logic                   req_ok, req_bad, wrap, pend_hit;

  assign req_ok   = sel_req && ((sel_vec == '0) || is_onehot(sel_vec));
  assign req_bad  = sel_req && !req_ok;
  assign wrap     = (cnt == n_cur - ONE_W);
  // A request landing on the wrap cycle is applied at that same boundary.
  assign pend_hit = req_ok || (state == PEND);
  assign pend_val = req_ok ? sel_vec : pend;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    n_nxt     = n_cur;
    cur_nxt   = cur_sel;
    pend_nxt  = pend;
    ack_nxt   = 1'b0;
    en_nxt    = 1'b0;

    case (state)
      PARK: begin
        if (req_ok) begin
          ack_nxt = 1'b1;
          if (sel_vec != '0) begin
            state_nxt = RUN;
            cur_nxt   = sel_vec;
            n_nxt     = ratio_of(sel_vec, div_vec);
            cnt_nxt   = '0;
          end
        end
      end
      default: begin
        en_nxt = wrap;
        if (wrap) begin
          cnt_nxt = '0;
          if (pend_hit) begin
            ack_nxt   = 1'b1;
            cur_nxt   = pend_val;
            n_nxt     = ratio_of(pend_val, div_vec);
            pend_nxt  = '0;
            state_nxt = (pend_val == '0) ? PARK : RUN;
          end else begin
            // Re-latch so a div_vec write only affects whole periods.
            n_nxt     = ratio_of(cur_sel, div_vec);
            state_nxt = RUN;
          end
        end else begin
          cnt_nxt = cnt + ONE_W;
          if (req_ok) begin
            pend_nxt  = sel_vec;
            state_nxt = PEND;
          end
        end
      end
    endcase

    // An error that collides with an ack is owed and issued on a later cycle.
    err_nxt  = (req_bad || err_owed) && !ack_nxt;
    owed_nxt = (req_bad || err_owed) && ack_nxt;
    busy_nxt = (state_nxt == PEND);
  end

`ifdef CLK_EN_SEL_DUTY50_EN
  logic [P_DIV_W:0] half;
  logic             lvl_nxt;
  assign half    = ({1'b0, n_nxt} + (P_DIV_W + 1)'(1)) >> 1;
  assign lvl_nxt = (state_nxt != PARK) && ({1'b0, cnt_nxt} < half);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clk_lvl_o <= 1'b0;
    else        clk_lvl_o <= lvl_nxt;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PARK;
      cnt      <= '0;
      n_cur    <= ONE_W;
      cur_sel  <= '0;
      pend     <= '0;
      err_owed <= 1'b0;
      sel_ack  <= 1'b0;
      sel_err  <= 1'b0;
      busy     <= 1'b0;
      clk_en_o <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      n_cur    <= n_nxt;
      cur_sel  <= cur_nxt;
      pend     <= pend_nxt;
      err_owed <= owed_nxt;
      sel_ack  <= ack_nxt;
      sel_err  <= err_nxt;
      busy     <= busy_nxt;
      clk_en_o <= en_nxt;
    end
  end

endmodule

// File: tb/tb_clk_en_sel.sv
// Self-checking bench for clk_en_sel: directed scenarios with literal
// expectations plus randomized traffic against a cycle-time reference model.
module tb_clk_en_sel;

  localparam int NC = 4;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NC*W-1:0] div_vec;
  logic            sel_req = 1'b0;
  logic [NC-1:0]   sel_vec = '0;
  logic            sel_ack, sel_err, busy, clk_en_o;
  logic [NC-1:0]   cur_sel;
`ifdef CLK_EN_SEL_DUTY50_EN
  logic            clk_lvl_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  clk_en_sel #(.P_NO_CLOCKS(NC), .P_DIV_W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .div_vec  (div_vec),
    .sel_req  (sel_req),
    .sel_vec  (sel_vec),
    .sel_ack  (sel_ack),
    .sel_err  (sel_err),
    .busy     (busy),
    .cur_sel  (cur_sel),
    .clk_en_o (clk_en_o)
`ifdef CLK_EN_SEL_DUTY50_EN
    ,
    .clk_lvl_o(clk_lvl_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: absolute cycle arithmetic ----------------
  int            cyc = 0;
  int            m_n = 1;
  int            m_start = 0;
  bit            m_run = 0, m_pend = 0, m_owed = 0;
  bit            m_ack = 0, m_err = 0, m_en = 0, m_busy = 0, m_lvl = 0;
  logic [NC-1:0] m_sel = '0, m_pval = '0;
  int            t_now;
  bit            m_bnd, m_bad;

  function automatic int ratio(input logic [NC-1:0] v);
    int r = 0;
    for (int i = 0; i < NC; i++) if (v[i]) r = int'(div_vec[i*W +: W]);
    return (r == 0) ? 1 : r;
  endfunction

  task automatic m_apply(input logic [NC-1:0] v, input int t);
    m_ack   = 1;
    m_sel   = v;
    m_run   = (v != '0);
    m_n     = ratio(v);
    m_start = t + 1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_pend = 0; m_owed = 0; m_ack = 0; m_err = 0;
      m_en = 0; m_busy = 0; m_lvl = 0; m_sel = '0; m_pval = '0; m_n = 1;
    end else begin
      t_now = cyc;
      m_ack = 0; m_err = 0; m_en = 0;
      m_bnd = m_run && (t_now == m_start + m_n - 1);
      m_bad = sel_req && (sel_vec != '0) && !$onehot(sel_vec);
      if (sel_req && !m_bad) begin
        if (!m_run) m_apply(sel_vec, t_now);
        else begin m_pend = 1; m_pval = sel_vec; end
      end
      if (m_bnd) begin
        m_en = 1;
        if (m_pend) begin m_apply(m_pval, t_now); m_pend = 0; end
        else begin m_start = t_now + 1; m_n = ratio(m_sel); end
      end
      if (m_bad || m_owed) begin
        if (m_ack) m_owed = 1;
        else begin m_err = 1; m_owed = 0; end
      end
      m_busy = m_pend;
      cyc    = t_now + 1;
      m_lvl  = m_run && ((cyc - m_start) < (m_n + 1) / 2);
    end
  end

  always @(negedge clk) begin
    check("sel_ack",  32'(sel_ack),  32'(m_ack));
    check("sel_err",  32'(sel_err),  32'(m_err));
    check("busy",     32'(busy),     32'(m_busy));
    check("cur_sel",  32'(cur_sel),  32'(m_sel));
    check("clk_en_o", 32'(clk_en_o), 32'(m_en));
`ifdef CLK_EN_SEL_DUTY50_EN
    check("clk_lvl_o", 32'(clk_lvl_o), 32'(m_lvl));
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic req(input logic [NC-1:0] v);
    @(posedge clk); #1 sel_req = 1'b1; sel_vec = v;
    @(posedge clk); #1 sel_req = 1'b0; sel_vec = '0;
  endtask

  task automatic req_pair(input logic [NC-1:0] a, input logic [NC-1:0] b);
    @(posedge clk); #1 sel_req = 1'b1; sel_vec = a;
    @(posedge clk); #1 sel_vec = b;
    @(posedge clk); #1 sel_req = 1'b0; sel_vec = '0;
  endtask

  task automatic wait_strobe(output int c);
    c = 0;
    do begin
      @(posedge clk); #1;
      c++;
    end while (!clk_en_o && c < 300);
  endtask

  task automatic wait_ack(input string name);
    int c = 0;
    while (!sel_ack && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    check(name, 32'(sel_ack), 32'd1);
  endtask

  task automatic set_ratio(input int idx, input int val);
    div_vec[idx*W +: W] = W'(val);
  endtask

  int g, acks, rst_cd;

  initial begin
    div_vec = '0;
    set_ratio(0, 2); set_ratio(1, 5); set_ratio(2, 4); set_ratio(3, 3);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ack",  32'(sel_ack),  32'd0);
    check("rst_err",  32'(sel_err),  32'd0);
    check("rst_busy", 32'(busy),     32'd0);
    check("rst_sel",  32'(cur_sel),  32'd0);
    check("rst_en",   32'(clk_en_o), 32'd0);

    // Start from park at ratio 5.
    req(4'b0010);
    check("park_ack", 32'(sel_ack), 32'd1);
    check("park_sel", 32'(cur_sel), 32'h2);
    wait_strobe(g); check("first_gap5", g, 5);
`ifdef CLK_EN_SEL_DUTY50_EN
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      if (clk_lvl_o) acks++;
      @(posedge clk); #1;
    end
    check("duty_high3", acks, 3);
`else
    wait_strobe(g);
`endif
    check("gap5", g, 5);

    // Mid-period switch to ratio 3.
    req(4'b1000);
    check("pend_busy", 32'(busy), 32'd1);
    wait_strobe(g);
    check("old_period", g, 3);
    check("sw_ack", 32'(sel_ack), 32'd1);
    check("sw_busy", 32'(busy), 32'd0);
    check("sw_sel", 32'(cur_sel), 32'h8);
    wait_strobe(g); check("gap3_a", g, 3);
    wait_strobe(g); check("gap3_b", g, 3);

    // Two requests back to back: last one wins, one ack.
    req_pair(4'b0001, 4'b0100);
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      if (sel_ack) acks++;
      @(posedge clk); #1;
    end
    check("pair_acks", acks, 1);
    check("pair_sel", 32'(cur_sel), 32'h4);

    // Malformed request.
    req(4'b0110);
    check("bad_err", 32'(sel_err), 32'd1);
    check("bad_ack", 32'(sel_ack), 32'd0);
    check("bad_sel", 32'(cur_sel), 32'h4);
    check("bad_busy", 32'(busy), 32'd0);
    wait_strobe(g);
    wait_strobe(g); check("bad_gap4", g, 4);

    // div_vec rewrite mid-period: period in progress keeps ratio 4.
    @(posedge clk); #1 set_ratio(2, 2);
    wait_strobe(g); check("rewrite_rest", g, 3);
    wait_strobe(g); check("rewrite_gap2a", g, 2);
    wait_strobe(g); check("rewrite_gap2b", g, 2);

    // Ratio 0 behaves as 1: enable held high.
    set_ratio(0, 0);
    req(4'b0001);
    wait_ack("r0_ack");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("r0_high", 32'(clk_en_o), 32'd1);
    end

    // Park at the boundary.
    req(4'b0000);
    wait_ack("park0_ack");
    check("park0_sel", 32'(cur_sel), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("park0_en", 32'(clk_en_o), 32'd0);
    end

    // Asynchronous reset while a request is pending.
    req(4'b0010);
    @(posedge clk); #1;
    req(4'b1000);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_sel",  32'(cur_sel), 32'd0);
    check("arst_ack",  32'(sel_ack), 32'd0);
    check("arst_err",  32'(sel_err), 32'd0);
    check("arst_en",   32'(clk_en_o), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Randomized traffic, small ratios so many boundaries occur.
    for (int i = 0; i < NC; i++) set_ratio(i, $urandom_range(0, 6));
    rst_cd = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      sel_req = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 4))
        0, 1:    sel_vec = NC'(1 << $urandom_range(0, NC - 1));
        2:       sel_vec = '0;
        default: sel_vec = NC'($urandom);
      endcase
      if ($urandom_range(0, 15) == 0) set_ratio($urandom_range(0, NC - 1), $urandom_range(0, 6));
      #2;
      if (!rst_n) begin
        if (rst_cd == 0) rst_n = 1'b1;
        else rst_cd--;
      end else if ($urandom_range(0, 599) == 0) begin
        rst_n  = 1'b0;
        rst_cd = 2;
      end
    end
    @(posedge clk); #1 sel_req = 1'b0; rst_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
